// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, ALUOp encodings, R-type funct
// values, forwarding-source select and the ALU control decode.
// No ports (package).
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_MUL = 3'd3;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_MUL = 6'h18;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    // Reserved ALUOp and unknown funct both fall back to add.
    function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                              input logic [5:0] funct);
        logic [2:0] code;
        code = ALU_ADD;
        case (aluop)
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_SUB: code = ALU_SUB;
                    FUNCT_AND: code = ALU_AND;
                    FUNCT_OR:  code = ALU_OR;
                    FUNCT_MUL: code = ALU_MUL;
                    FUNCT_SLT: code = ALU_SLT;
                    default:   code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select. Purely combinational.
// Ports:
//   i_rs_addr, i_rt_addr        registered source fields in EX
//   i_exmem_we, i_exmem_rd      EX/MEM write-back info (highest priority)
//   i_memwb_we, i_memwb_rd      MEM/WB write-back info
//   o_fwd_a, o_fwd_b            source select for operand A (rs) / B (rt)
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] i_rs_addr,
    input  logic [RA_W-1:0] i_rt_addr,
    input  logic            i_exmem_we,
    input  logic [RA_W-1:0] i_exmem_rd,
    input  logic            i_memwb_we,
    input  logic [RA_W-1:0] i_memwb_rd,
    output fwd_sel_e        o_fwd_a,
    output fwd_sel_e        o_fwd_b
);

    // Register 0 is hard-wired, so a write to it is never a forwarding source.
    function automatic fwd_sel_e pick(input logic [RA_W-1:0] src,
                                      input logic            exmem_we,
                                      input logic [RA_W-1:0] exmem_rd,
                                      input logic            memwb_we,
                                      input logic [RA_W-1:0] memwb_rd);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src)) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

    always_comb begin
        o_fwd_a = pick(i_rs_addr, i_exmem_we, i_exmem_rd, i_memwb_we, i_memwb_rd);
        o_fwd_b = pick(i_rt_addr, i_exmem_we, i_exmem_rd, i_memwb_we, i_memwb_rd);
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with same-cycle operand forwarding, ALU control
// decode and load-use hazard detection.
// Ports:
//   clk_i, rst_n_i                   clock / async active-low reset
//   stall_i, flush_i, valid_i        capture control (flush > stall > load)
//   rs/rt_data_i, imm_i, *_addr_i    ID operands and register fields
//   ALUSrc_i..MemtoReg_i, ALUOp_i,   decoded control
//   funct_i
//   exmem_*, memwb_*                 forwarding sources
//   id_rs/rt_addr_i                  sources of the instruction now in ID
//   data1_o, data2_o, ALUCtrl_o      ALU operands and operation
//   store_data_o, wr_addr_o          forwarded rt and destination register
//   valid_o..MemtoReg_o              registered control to EX/MEM
//   load_use_o                       load-use hazard flag
module ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [RA_W-1:0]   rs_addr_i,
    input  logic [RA_W-1:0]   rt_addr_i,
    input  logic [RA_W-1:0]   rd_addr_i,
    input  logic              ALUSrc_i,
    input  logic              RegDst_i,
    input  logic              RegWrite_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              MemtoReg_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic              exmem_RegWrite_i,
    input  logic [RA_W-1:0]   exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_data_i,
    input  logic              memwb_RegWrite_i,
    input  logic [RA_W-1:0]   memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_data_i,
    input  logic [RA_W-1:0]   id_rs_addr_i,
    input  logic [RA_W-1:0]   id_rt_addr_i,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic [2:0]        ALUCtrl_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [RA_W-1:0]   wr_addr_o,
    output logic              valid_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemtoReg_o,
    output logic              load_use_o
);

    logic              r_valid;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [RA_W-1:0]   r_rs_addr;
    logic [RA_W-1:0]   r_rt_addr;
    logic [RA_W-1:0]   r_rd_addr;
    logic              r_alusrc;
    logic              r_regdst;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_memwrite;
    logic              r_memtoreg;
    logic [1:0]        r_aluop;
    logic [5:0]        r_funct;

    fwd_sel_e          w_fwd_a;
    fwd_sel_e          w_fwd_b;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [RA_W-1:0]   w_wr_addr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid    <= 1'b0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_rd_addr  <= '0;
            r_alusrc   <= 1'b0;
            r_regdst   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_aluop    <= '0;
            r_funct    <= '0;
        end else if (flush_i) begin
            r_valid    <= 1'b0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_rs_addr  <= '0;
            r_rt_addr  <= '0;
            r_rd_addr  <= '0;
            r_alusrc   <= 1'b0;
            r_regdst   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_aluop    <= '0;
            r_funct    <= '0;
        end else if (!stall_i) begin
            // Control is gated by valid so a captured bubble can never write
            // state downstream, whatever ID left on the control lines.
            r_valid    <= valid_i;
            r_rs_data  <= rs_data_i;
            r_rt_data  <= rt_data_i;
            r_imm      <= imm_i;
            r_rs_addr  <= rs_addr_i;
            r_rt_addr  <= rt_addr_i;
            r_rd_addr  <= rd_addr_i;
            r_alusrc   <= ALUSrc_i;
            r_regdst   <= RegDst_i;
            r_regwrite <= RegWrite_i & valid_i;
            r_memread  <= MemRead_i  & valid_i;
            r_memwrite <= MemWrite_i & valid_i;
            r_memtoreg <= MemtoReg_i & valid_i;
            r_aluop    <= ALUOp_i;
            r_funct    <= funct_i;
        end
    end

    fwd_unit #(.RA_W(RA_W)) u_fwd (
        .i_rs_addr  (r_rs_addr),
        .i_rt_addr  (r_rt_addr),
        .i_exmem_we (exmem_RegWrite_i),
        .i_exmem_rd (exmem_rd_i),
        .i_memwb_we (memwb_RegWrite_i),
        .i_memwb_rd (memwb_rd_i),
        .o_fwd_a    (w_fwd_a),
        .o_fwd_b    (w_fwd_b)
    );

    always_comb begin
        case (w_fwd_a)
            FWD_EXMEM: w_op_a = exmem_data_i;
            FWD_MEMWB: w_op_a = memwb_data_i;
            default:   w_op_a = r_rs_data;
        endcase
        case (w_fwd_b)
            FWD_EXMEM: w_op_b = exmem_data_i;
            FWD_MEMWB: w_op_b = memwb_data_i;
            default:   w_op_b = r_rt_data;
        endcase
    end

    assign w_wr_addr    = r_regdst ? r_rd_addr : r_rt_addr;

    assign data1_o      = w_op_a;
    assign store_data_o = w_op_b;
    assign data2_o      = r_alusrc ? r_imm : w_op_b;
    assign wr_addr_o    = w_wr_addr;

    // A bubble presents AND (code 0) so a cleared stage reads as all-zero.
    assign ALUCtrl_o    = r_valid ? alu_decode(r_aluop, r_funct) : ALU_AND;

    assign valid_o      = r_valid;
    assign RegWrite_o   = r_regwrite;
    assign MemRead_o    = r_memread;
    assign MemWrite_o   = r_memwrite;
    assign MemtoReg_o   = r_memtoreg;

    assign load_use_o   = r_valid & r_memread & (w_wr_addr != '0) &
                          ((w_wr_addr == id_rs_addr_i) | (w_wr_addr == id_rt_addr_i));

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              stall_i, flush_i, valid_i;
    logic [DATA_W-1:0] rs_data_i, rt_data_i, imm_i;
    logic [RA_W-1:0]   rs_addr_i, rt_addr_i, rd_addr_i;
    logic              ALUSrc_i, RegDst_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
    logic [1:0]        ALUOp_i;
    logic [5:0]        funct_i;
    logic              exmem_RegWrite_i, memwb_RegWrite_i;
    logic [RA_W-1:0]   exmem_rd_i, memwb_rd_i, id_rs_addr_i, id_rt_addr_i;
    logic [DATA_W-1:0] exmem_data_i, memwb_data_i;
    logic [DATA_W-1:0] data1_o, data2_o, store_data_o;
    logic [2:0]        ALUCtrl_o;
    logic [RA_W-1:0]   wr_addr_o;
    logic              valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, load_use_o;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk_i = ~clk_i;

    ex_operand_stage #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
        .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
        .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .RegWrite_i(RegWrite_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i),
        .exmem_RegWrite_i(exmem_RegWrite_i), .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
        .memwb_RegWrite_i(memwb_RegWrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
        .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o),
        .store_data_o(store_data_o), .wr_addr_o(wr_addr_o), .valid_o(valid_o),
        .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .load_use_o(load_use_o)
    );

    // Reference model: the instruction the stage currently holds.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data, rt_data, imm;
        logic [RA_W-1:0]   rs, rt, rd;
        logic              alusrc, regdst, regwrite, memread, memwrite, memtoreg;
        logic [1:0]        aluop;
        logic [5:0]        funct;
    } instr_t;

    instr_t m;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || flush_i) begin
            m <= '0;
        end else if (!stall_i) begin
            m <= '{valid: valid_i, rs_data: rs_data_i, rt_data: rt_data_i, imm: imm_i,
                   rs: rs_addr_i, rt: rt_addr_i, rd: rd_addr_i,
                   alusrc: ALUSrc_i, regdst: RegDst_i,
                   regwrite: RegWrite_i && valid_i, memread: MemRead_i && valid_i,
                   memwrite: MemWrite_i && valid_i, memtoreg: MemtoReg_i && valid_i,
                   aluop: ALUOp_i, funct: funct_i};
        end
    end

    function automatic int operand(input int addr, input int rf_value);
        if (exmem_RegWrite_i && int'(exmem_rd_i) != 0 && int'(exmem_rd_i) == addr)
            return int'(exmem_data_i);
        if (memwb_RegWrite_i && int'(memwb_rd_i) != 0 && int'(memwb_rd_i) == addr)
            return int'(memwb_data_i);
        return rf_value;
    endfunction

    function automatic int alu_code(input instr_t s);
        if (!s.valid) return 0;
        if (s.aluop == 2'b01) return 6;
        if (s.aluop != 2'b10) return 2;
        case (int'(s.funct))
            'h22: return 6;
            'h24: return 0;
            'h25: return 1;
            'h18: return 3;
            'h2A: return 7;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_all();
        int a, b, dst, lu;
        a   = operand(int'(m.rs), int'(m.rs_data));
        b   = operand(int'(m.rt), int'(m.rt_data));
        dst = m.regdst ? int'(m.rd) : int'(m.rt);
        lu  = (m.valid && m.memread && dst != 0 &&
               (dst == int'(id_rs_addr_i) || dst == int'(id_rt_addr_i))) ? 1 : 0;
        chk("model data1", int'(data1_o), a);
        chk("model data2", int'(data2_o), m.alusrc ? int'(m.imm) : b);
        chk("model store", int'(store_data_o), b);
        chk("model aluctrl", int'(ALUCtrl_o), alu_code(m));
        chk("model wr_addr", int'(wr_addr_o), dst);
        chk("model ctrl", int'({valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}),
            int'({m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg}));
        chk("model load_use", int'(load_use_o), lu);
    endtask

    // Single compare point per cycle, after stimulus has settled.
    always @(negedge clk_i) begin
        #2;
        compare_all();
    end

    task automatic idle();
        stall_i = 0; flush_i = 0; valid_i = 0;
        rs_data_i = '0; rt_data_i = '0; imm_i = '0;
        rs_addr_i = '0; rt_addr_i = '0; rd_addr_i = '0;
        ALUSrc_i = 0; RegDst_i = 0; RegWrite_i = 0; MemRead_i = 0; MemWrite_i = 0; MemtoReg_i = 0;
        ALUOp_i = '0; funct_i = '0;
        exmem_RegWrite_i = 0; exmem_rd_i = '0; exmem_data_i = '0;
        memwb_RegWrite_i = 0; memwb_rd_i = '0; memwb_data_i = '0;
        id_rs_addr_i = '0; id_rt_addr_i = '0;
    endtask

    task automatic randomize_id();
        valid_i    = 1'($urandom_range(0, 3) != 0);
        rs_data_i  = $urandom(); rt_data_i = $urandom(); imm_i = $urandom();
        rs_addr_i  = 5'($urandom_range(0, 3));
        rt_addr_i  = 5'($urandom_range(0, 3));
        rd_addr_i  = 5'($urandom_range(0, 3));
        ALUSrc_i   = 1'($urandom()); RegDst_i = 1'($urandom()); RegWrite_i = 1'($urandom());
        MemRead_i  = 1'($urandom()); MemWrite_i = 1'($urandom()); MemtoReg_i = 1'($urandom());
        ALUOp_i    = 2'($urandom());
        case ($urandom_range(0, 7))
            0: funct_i = 6'h20; 1: funct_i = 6'h22; 2: funct_i = 6'h24; 3: funct_i = 6'h25;
            4: funct_i = 6'h18; 5: funct_i = 6'h2A; default: funct_i = 6'($urandom());
        endcase
    endtask

    task automatic randomize_fwd();
        exmem_RegWrite_i = 1'($urandom()); exmem_rd_i = 5'($urandom_range(0, 3));
        exmem_data_i     = $urandom();
        memwb_RegWrite_i = 1'($urandom()); memwb_rd_i = 5'($urandom_range(0, 3));
        memwb_data_i     = $urandom();
        id_rs_addr_i     = 5'($urandom_range(0, 3)); id_rt_addr_i = 5'($urandom_range(0, 3));
    endtask

    // Load the driven instruction on the next edge, then settle past the compare point.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
        #3;
    endtask

    localparam int FUNCTS [7] = '{'h20, 'h22, 'h24, 'h25, 'h18, 'h2A, 'h00};
    localparam int CODES  [7] = '{2, 6, 0, 1, 3, 7, 2};

    initial begin
        idle();
        #5;
        chk("reset data1", int'(data1_o), 0);
        chk("reset aluctrl", int'(ALUCtrl_o), 0);
        chk("reset ctrl", int'({valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}), 0);
        #10 rst_n_i = 1'b1;
        @(negedge clk_i); #3;

        // Stall hold: add r3,r1,r2 then three stalled edges with fresh inputs.
        valid_i = 1; rs_addr_i = 1; rt_addr_i = 2; rd_addr_i = 3; RegDst_i = 1; RegWrite_i = 1;
        rs_data_i = 5; rt_data_i = 7; ALUOp_i = 2'b10; funct_i = 6'h20;
        step();
        for (int i = 0; i < 3; i++) begin
            randomize_id();
            stall_i = 1;
            step();
            chk("stall data1", int'(data1_o), 5);
            chk("stall data2", int'(data2_o), 7);
            chk("stall aluctrl", int'(ALUCtrl_o), 2);
        end

        // Double forward on r4 for both operands.
        idle();
        valid_i = 1; rs_addr_i = 4; rt_addr_i = 4; rs_data_i = 'h11; rt_data_i = 'h22;
        step();
        stall_i = 1;
        exmem_RegWrite_i = 1; exmem_rd_i = 4; exmem_data_i = 'hAA;
        memwb_RegWrite_i = 1; memwb_rd_i = 4; memwb_data_i = 'hBB;
        #1;
        chk("fwd exmem a", int'(data1_o), 'hAA);
        chk("fwd exmem b", int'(data2_o), 'hAA);
        exmem_RegWrite_i = 0;
        #1;
        chk("fwd memwb a", int'(data1_o), 'hBB);
        chk("fwd memwb b", int'(data2_o), 'hBB);
        exmem_RegWrite_i = 1; exmem_rd_i = 0; memwb_rd_i = 0;
        #1;
        chk("fwd r0 a", int'(data1_o), 'h11);
        chk("fwd r0 b", int'(data2_o), 'h22);

        // ALU control decode sweep.
        for (int i = 0; i < 7; i++) begin
            idle();
            valid_i = 1; ALUOp_i = 2'b10; funct_i = 6'(FUNCTS[i]);
            step();
            chk($sformatf("decode funct %0h", FUNCTS[i]), int'(ALUCtrl_o), CODES[i]);
        end
        idle(); valid_i = 1; ALUOp_i = 2'b00; funct_i = 6'h22;
        step();
        chk("decode aluop00", int'(ALUCtrl_o), 2);
        idle(); valid_i = 1; ALUOp_i = 2'b01; funct_i = 6'h20;
        step();
        chk("decode aluop01", int'(ALUCtrl_o), 6);

        // Store: immediate operand with rt forwarded from MEM/WB.
        idle();
        valid_i = 1; ALUSrc_i = 1; imm_i = 'h10; rt_addr_i = 6; rt_data_i = 'h99; MemWrite_i = 1;
        step();
        memwb_RegWrite_i = 1; memwb_rd_i = 6; memwb_data_i = 'h1234;
        #1;
        chk("store data2", int'(data2_o), 'h10);
        chk("store data", int'(store_data_o), 'h1234);
        chk("store memwrite", int'(MemWrite_o), 1);

        // Load-use detection.
        idle();
        valid_i = 1; MemRead_i = 1; RegWrite_i = 1; MemtoReg_i = 1; rt_addr_i = 8;
        step();
        id_rs_addr_i = 1; id_rt_addr_i = 8;
        #1 chk("load_use hit", int'(load_use_o), 1);
        id_rs_addr_i = 9; id_rt_addr_i = 10;
        #1 chk("load_use miss", int'(load_use_o), 0);
        idle();
        valid_i = 1; MemRead_i = 1; rt_addr_i = 0;
        step();
        id_rs_addr_i = 0; id_rt_addr_i = 0;
        #1 chk("load_use r0", int'(load_use_o), 0);

        // Flush and stall together: flush wins.
        idle();
        valid_i = 1; RegWrite_i = 1; rt_addr_i = 3;
        step();
        flush_i = 1; stall_i = 1;
        step();
        chk("flush valid", int'(valid_o), 0);
        chk("flush regwrite", int'(RegWrite_o), 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            randomize_id();
            randomize_fwd();
            stall_i = 1'($urandom_range(0, 7) == 0);
            flush_i = 1'($urandom_range(0, 9) == 0);
            @(negedge clk_i);
        end

        // Async reset mid-cycle with a loaded, stalled instruction.
        idle();
        valid_i = 1; RegWrite_i = 1; MemRead_i = 1; rs_addr_i = 2; rt_addr_i = 3;
        rs_data_i = 'h55; rt_data_i = 'h66; imm_i = 'h77; ALUOp_i = 2'b01;
        step();
        stall_i = 1;
        #1 rst_n_i = 1'b0;
        #1;
        chk("async rst data1", int'(data1_o), 0);
        chk("async rst data2", int'(data2_o), 0);
        chk("async rst aluctrl", int'(ALUCtrl_o), 0);
        chk("async rst ctrl", int'({valid_o, RegWrite_o, MemRead_o, wr_addr_o}), 0);
        #2 rst_n_i = 1'b1;
        idle();
        @(negedge clk_i); #3;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and ALU-control decode for the 5-stage CPU.
- Sits directly upstream of the ALU and drives its two operands and 3-bit operation code.
- Also flags load-use hazards to the hazard unit and carries the EX/MEM control bits forward.

Parameters:
DATA_W, 32, datapath width
RA_W, 5, register-address width

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
stall_i  in  1  hold the current contents (no capture)
flush_i  in  1  insert a bubble on the next edge
valid_i  in  1  ID holds a real instruction
rs_data_i, rt_data_i  in  DATA_W  register-file read data
imm_i  in  DATA_W  sign-extended immediate
rs_addr_i, rt_addr_i, rd_addr_i  in  RA_W  instruction register fields
ALUSrc_i, RegDst_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i  in  1  decoded control
ALUOp_i  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved
funct_i  in  6  R-type funct field
exmem_RegWrite_i  in  1  EX/MEM forwarding source: write enable
exmem_rd_i  in  RA_W  EX/MEM forwarding source: destination
exmem_data_i  in  DATA_W  EX/MEM forwarding source: data
memwb_RegWrite_i  in  1  MEM/WB forwarding source: write enable
memwb_rd_i  in  RA_W  MEM/WB forwarding source: destination
memwb_data_i  in  DATA_W  MEM/WB forwarding source: data
id_rs_addr_i, id_rt_addr_i  in  RA_W  source fields of the instruction now in ID
data1_o, data2_o  out  DATA_W  ALU operands
ALUCtrl_o  out  3  ALU operation code
store_data_o  out  DATA_W  forwarded rt value for stores
wr_addr_o  out  RA_W  destination register
valid_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o  out  1  registered control
load_use_o  out  1  load-use hazard flag

Behaviour:
- Reset (async, rst_n_i=0): every stage register cleared to 0. Result: all outputs 0, ALUCtrl_o=And(0), load_use_o=0.
- Capture at each rising edge, with priority flush > stall > load:
  - flush_i=1: valid and all control bits cleared; data/address fields also cleared to 0.
  - stall_i=1: all fields hold.
  - otherwise: all *_i fields captured.
- Simultaneous flush_i and stall_i: flush wins.
- Latency: one cycle from ID inputs to registered fields. All outputs are combinational from registered fields and the forwarding inputs (same-cycle forwarding).
- Forward select for operand A (rs_q); operand B (rt_q) uses identical rules:
  - EX/MEM if exmem_RegWrite_i and exmem_rd_i!=0 and exmem_rd_i==rs_q;
  - else MEM/WB under the same rule;
  - else the registered register-file data.
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - data1_o = forwarded A.
  - store_data_o = forwarded B.
  - data2_o = imm_q if ALUSrc_q, else forwarded B.
- wr_addr_o = rd_q if RegDst_q, else rt_q.
- ALU control decode:
  - ALUOp 00 -> Add(2); 01 -> Sub(6); 11 -> Add(2).
  - ALUOp 10, by funct: 0x20 Add(2), 0x22 Sub(6), 0x24 And(0), 0x25 Or(1), 0x18 Mul(3), 0x2A Slt(7), any other funct -> Add(2).
- load_use_o = valid_q & MemRead_q & (wr_addr_o!=0) & (wr_addr_o==id_rs_addr_i | wr_addr_o==id_rt_addr_i).
  - Purely combinational.
  - The hazard unit answers it by stalling IF/ID and driving flush_i here. There is no internal feedback path from load_use_o to capture.
- A bubble (valid_q=0) has all control bits 0, so it never writes state downstream.
- Reset asserted mid-stall or mid-flush: the block clears immediately, with no residual state.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU codes ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_MUL=3, ALU_SUB=6, ALU_SLT=7;
  - ALUOp encodings;
  - funct constants.
- One natural sub-module: fwd_unit. It is combinational and produces the 2-bit A/B source selects from the register addresses and the EX/MEM and MEM/WB write info.
- Decode and pipeline register stay inline.

Test Plan:
- Reset/flush:
  - Assert rst_n_i=0 mid-cycle with valid fields loaded -> all outputs 0 immediately, with no clock edge.
  - Separately, flush_i=1 & stall_i=1 on one edge -> valid_o=0, RegWrite_o=0.
- Stall hold: load add r3,r1,r2 (rs=0x5, rt=0x7), then stall_i=1 for 3 edges with new inputs -> data1_o=5, data2_o=7, ALUCtrl_o=2 held throughout.
- Double forward: rs_q=rt_q=4 with exmem rd=4 (data 0xAA) and memwb rd=4 (data 0xBB), both RegWrite=1 -> data1_o=data2_o=0xAA. With exmem_RegWrite_i=0 -> 0xBB. With rd=0 -> the register-file values.
- Decode sweep: ALUOp=10 with each funct in {0x20,0x22,0x24,0x25,0x18,0x2A,0x00} -> ALUCtrl_o {2,6,0,1,3,7,2}. ALUOp 00 -> 2, ALUOp 01 -> 6.
- Immediate/store: sw with ALUSrc=1, imm=0x10, rt forwarded from MEM/WB (data 0x1234) -> data2_o=0x10, store_data_o=0x1234.
- Load-use: registered lw to r8, id_rt_addr_i=8 -> load_use_o=1. Then id addresses 9/10 -> 0. Then lw to r0 -> 0.
